// File: rtl/test2_arb_pkg.sv
// Shared types and helpers for the test_2 unit arbiter.
package test2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int CNT_W = 4;

  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/test2_unit_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick
  import test2_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/test2_unit_arbiter.sv
// Shares one fixed-latency test_2 unit among NREQ requesters, round-robin.
//   state | meaning
//   IDLE  | unit parked at IDLE_ABC, grant offered to the round-robin winner
//   WAIT  | operands held on the unit, cnt counts down the unit latency
//   RESP  | result held on rsp_* until rsp_ready
module test2_unit_arbiter
  import test2_arb_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter int         LAT      = 1,
  parameter logic [2:0] IDLE_ABC = 3'b111,
  localparam int        IDW      = idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  input  logic [NREQ-1:0] req_c,
  output logic [NREQ-1:0] req_ready,
  output logic            unit_a,
  output logic            unit_b,
  output logic            unit_c,
  input  logic            unit_d,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_d,
  output logic            busy
);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr, id_q, win_idx, next_ptr;
  logic [NREQ-1:0]  gnt;
  logic             found, hs, cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       abc_q;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .found (found),
    .idx   (win_idx)
  );

  assign hs       = (state_q == IDLE) && found;
  assign cnt_zero = (cnt == '0);
  assign next_ptr = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

  assign {unit_a, unit_b, unit_c} = abc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs)        state_d = WAIT;
      WAIT:    if (cnt_zero)  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    if (state_q == IDLE) begin
      req_ready = gnt;
      busy      = 1'b0;
    end
  end

  // Operand selection uses the one-hot grant as a mask, so no indexing by win_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      abc_q     <= IDLE_ABC;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_d     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            abc_q  <= {|(req_a & gnt), |(req_b & gnt), |(req_c & gnt)};
            id_q   <= win_idx;
            rr_ptr <= next_ptr;
            cnt    <= CNT_W'(LAT);
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            rsp_d     <= unit_d;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            abc_q     <= IDLE_ABC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test2_unit_arbiter.sv
// Bench for test2_unit_arbiter: a LAT=1 and a LAT=3 instance share stimulus.
module tb_test2_unit_arbiter;

  localparam int LATS [2] = '{1, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0, req_a = '0, req_b = '0, req_c = '0;
  logic       rsp_ready = 1'b0;

  logic [3:0] req_ready0, req_ready1;
  logic       unit_a0, unit_b0, unit_c0, unit_a1, unit_b1, unit_c1;
  logic       rsp_valid0, rsp_valid1, rsp_d0, rsp_d1, busy0, busy1;
  logic [1:0] rsp_id0, rsp_id1;
  logic       unit_d0 = 1'b0;
  logic [2:0] pipe1_q = '0;
  logic       unit_d1;

  always #5 clk = ~clk;

  function automatic logic f3(input logic [2:0] x);
    return (x[2] & x[1]) ^ x[0];
  endfunction

  // Behavioural test_2 units: d = f3(a,b,c) delayed by LAT register stages.
  always @(posedge clk) unit_d0 <= f3({unit_a0, unit_b0, unit_c0});
  always @(posedge clk) pipe1_q <= {pipe1_q[1:0], f3({unit_a1, unit_b1, unit_c1})};
  assign unit_d1 = pipe1_q[2];

  test2_unit_arbiter #(.NREQ(4), .LAT(1), .IDLE_ABC(3'b111)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_ready(req_ready0), .unit_a(unit_a0), .unit_b(unit_b0),
    .unit_c(unit_c0), .unit_d(unit_d0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id0), .rsp_d(rsp_d0), .busy(busy0)
  );

  test2_unit_arbiter #(.NREQ(4), .LAT(3), .IDLE_ABC(3'b111)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_ready(req_ready1), .unit_a(unit_a1), .unit_b(unit_b1),
    .unit_c(unit_c1), .unit_d(unit_d1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id1), .rsp_d(rsp_d1), .busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one outstanding operation per unit, tracked as a record
  // with the cycle at which its response becomes visible.
  bit         m_sync = 1'b0;
  bit         m_has  [2];
  int         m_ptr  [2];
  int         m_id   [2];
  bit         m_d    [2];
  logic [2:0] m_abc  [2];
  int         m_rcyc [2];

  task automatic model_cycle(input int k, input logic [3:0] rdy, input logic bsy,
                             input logic rv, input logic [1:0] id, input logic d,
                             input logic [2:0] abc);
    logic [3:0] e_rdy;
    logic [2:0] e_abc;
    bit         e_rv;
    int         w;
    e_rdy = '0;
    w     = -1;
    if (!m_has[k])
      for (int s = 0; s < 4; s++)
        if (w < 0 && req_valid[(m_ptr[k] + s) % 4]) w = (m_ptr[k] + s) % 4;
    if (w >= 0) e_rdy[w] = 1'b1;
    e_rv  = m_has[k] && (cyc >= m_rcyc[k]);
    e_abc = (m_has[k] && cyc < m_rcyc[k]) ? m_abc[k] : 3'b111;
    if (m_sync) begin
      chk($sformatf("mdl%0d req_ready", k), 32'(rdy), 32'(e_rdy));
      chk($sformatf("mdl%0d busy", k), 32'(bsy), 32'(m_has[k]));
      chk($sformatf("mdl%0d rsp_valid", k), 32'(rv), 32'(e_rv));
      chk($sformatf("mdl%0d unit_abc", k), 32'(abc), 32'(e_abc));
      if (e_rv) begin
        chk($sformatf("mdl%0d rsp_id", k), 32'(id), 32'(m_id[k]));
        chk($sformatf("mdl%0d rsp_d", k), 32'(d), 32'(m_d[k]));
      end
    end
    if (rst) begin
      m_has[k] = 1'b0;
      m_ptr[k] = 0;
    end else if (w >= 0) begin
      m_has[k]  = 1'b1;
      m_id[k]   = w;
      m_abc[k]  = {req_a[w], req_b[w], req_c[w]};
      m_d[k]    = f3(m_abc[k]);
      m_rcyc[k] = cyc + LATS[k] + 2;
      m_ptr[k]  = (w + 1) % 4;
    end else if (e_rv && rsp_ready) begin
      m_has[k] = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c, input logic rr);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_a = a; req_b = b; req_c = c; rsp_ready = rr;
    #3;
    model_cycle(0, req_ready0, busy0, rsp_valid0, rsp_id0, rsp_d0, {unit_a0, unit_b0, unit_c0});
    model_cycle(1, req_ready1, busy1, rsp_valid1, rsp_id1, rsp_d1, {unit_a1, unit_b1, unit_c1});
    if (r) m_sync = 1'b1;
    cyc++;
  endtask

  typedef struct {
    logic       r;
    logic [3:0] v, a, b, c;
    logic       rr;
    bit         chk;
    logic [3:0] e_rdy;
    logic       e_busy, e_rv;
    logic [1:0] e_id;
    logic       e_d;
    logic [2:0] e_abc;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic [3:0] v, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c, input logic rr,
                     input bit ck, input logic [3:0] er, input logic eb, input logic erv,
                     input logic [1:0] eid, input logic ed, input logic [2:0] eabc);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.b = b; t.c = c; t.rr = rr; t.chk = ck;
    t.e_rdy = er; t.e_busy = eb; t.e_rv = erv; t.e_id = eid; t.e_d = ed; t.e_abc = eabc;
    tbl.push_back(t);
  endtask

  initial begin
    logic [3:0] sa, sb, sc, ma, mb, mc;
    int         got_n, held;
    logic [1:0] got_id;
    logic       got_d;
    sa = 4'b0100; sb = 4'b0000; sc = 4'b0100;
    ma = 4'b1010; mb = 4'b1100; mc = 4'b0110;

    // Single request, backpressure, wrap-around, round-robin, reset mid-WAIT (LAT=1).
    row(1, 4'b0000, sa, sb, sc, 0, 0, 4'b0000, 0, 0, 0, 0, 3'b111);
    row(0, 4'b0000, sa, sb, sc, 0, 1, 4'b0000, 0, 0, 0, 0, 3'b111);
    row(0, 4'b0100, sa, sb, sc, 0, 1, 4'b0100, 0, 0, 0, 0, 3'b111);
    row(0, 4'b0000, sa, sb, sc, 0, 1, 4'b0000, 1, 0, 0, 0, 3'b101);
    row(0, 4'b0000, sa, sb, sc, 0, 1, 4'b0000, 1, 0, 0, 0, 3'b101);
    for (int i = 0; i < 5; i++)
      row(0, 4'b1111, ma, mb, mc, 0, 1, 4'b0000, 1, 1, 2, 1, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 1, 2, 1, 3'b111);
    row(0, 4'b0011, ma, mb, mc, 1, 1, 4'b0001, 0, 0, 0, 0, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b000);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b000);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 1, 0, 0, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0010, 0, 0, 0, 0, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b101);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b101);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 1, 1, 1, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0100, 0, 0, 0, 0, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b011);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b011);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 1, 2, 1, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b1000, 0, 0, 0, 0, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b110);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b110);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 1, 3, 1, 3'b111);
    row(0, 4'b1111, ma, mb, mc, 1, 1, 4'b0001, 0, 0, 0, 0, 3'b111);
    row(1, 4'b1111, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b000);
    row(0, 4'b0110, ma, mb, mc, 1, 1, 4'b0010, 0, 0, 0, 0, 3'b111);
    row(0, 4'b0000, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b101);
    row(0, 4'b0000, ma, mb, mc, 1, 1, 4'b0000, 1, 0, 0, 0, 3'b101);
    row(0, 4'b0000, ma, mb, mc, 1, 1, 4'b0000, 1, 1, 1, 1, 3'b111);
    row(0, 4'b0000, ma, mb, mc, 1, 1, 4'b0000, 0, 0, 0, 0, 3'b111);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].rr);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d req_ready", i), 32'(req_ready0), 32'(tbl[i].e_rdy));
        chk($sformatf("tbl%0d busy", i), 32'(busy0), 32'(tbl[i].e_busy));
        chk($sformatf("tbl%0d rsp_valid", i), 32'(rsp_valid0), 32'(tbl[i].e_rv));
        chk($sformatf("tbl%0d unit_abc", i), 32'({unit_a0, unit_b0, unit_c0}), 32'(tbl[i].e_abc));
        if (tbl[i].e_rv) begin
          chk($sformatf("tbl%0d rsp_id", i), 32'(rsp_id0), 32'(tbl[i].e_id));
          chk($sformatf("tbl%0d rsp_d", i), 32'(rsp_d0), 32'(tbl[i].e_d));
        end
      end
    end

    // LAT=3 instance: single request, measure hold time and response latency.
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    step(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    chk("lat3 grant", 32'(req_ready1), 32'(4'b0001));
    got_n = -1; held = 0; got_id = '1; got_d = 1'b0;
    for (int n = 1; n <= 20 && got_n < 0; n++) begin
      step(0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1);
      if ({unit_a1, unit_b1, unit_c1} == 3'b110) held++;
      if (rsp_valid1 === 1'b1) begin
        got_n  = n;
        got_id = rsp_id1;
        got_d  = rsp_d1;
      end
    end
    chk("lat3 resp cycle", 32'(got_n), 32'(5));
    chk("lat3 unit hold", 32'(held), 32'(4));
    chk("lat3 rsp_id", 32'(got_id), 32'(0));
    chk("lat3 rsp_d", 32'(got_d), 32'(1));

    // Randomized traffic, both instances checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test2_unit_arbiter.md
Name: test2_unit_arbiter

Overview:
- Shares one `test_2` compute unit (inputs a, b, c; output d; registered, fixed latency) among NREQ requesters.
- Grants one requester at a time in round-robin order and captures its operand triple.
- Drives the unit, waits the unit latency, and returns d tagged with the requester index.
- Sits between the requester logic and the single `test_2` instance; the only block allowed to drive its inputs.

Parameters:
- NREQ, 4, number of requesters (1..16).
- LAT, 1, `test_2` latency in clk cycles from a/b/c change to d valid (1..15).
- IDLE_ABC, 3'b111, value driven on {unit_a, unit_b, unit_c} when no operation is in flight.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ  per-requester operand a.
- req_b  in  NREQ  per-requester operand b.
- req_c  in  NREQ  per-requester operand c.
- req_ready  out  NREQ  one-hot grant/accept; transfer when req_valid[i] & req_ready[i].
- unit_a  out  1  to test_2 a.
- unit_b  out  1  to test_2 b.
- unit_c  out  1  to test_2 c.
- unit_d  in  1  from test_2 d.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_id  out  IDW  index of originating requester; IDW = max(1, clog2(NREQ)).
- rsp_d  out  1  returned d.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Synchronous reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0, cnt=0.
  - {unit_a, unit_b, unit_c} = IDLE_ABC.
  - rsp_valid=0, rsp_id=0, rsp_d=0, busy=0.
  - Any in-flight operation is aborted; no response is produced for it.
- State machine:
  - IDLE -> WAIT on a handshake.
  - WAIT -> RESP when cnt==0.
  - RESP -> IDLE when rsp_ready=1.
- IDLE, arbitration:
  - req_ready is combinational and one-hot: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready is all-zero if no req_valid is set, and all-zero in every state other than IDLE.
- Handshake at edge T (cycle T is the cycle where valid & ready):
  - Capture operands into {unit_a, unit_b, unit_c} and the winner index into id_q.
  - rr_ptr = (winner+1) mod NREQ.
  - cnt = LAT; state = WAIT.
- WAIT:
  - Unit inputs are held constant.
  - cnt decrements each cycle.
  - In the cycle where cnt==0: rsp_d <= unit_d, rsp_id <= id_q, rsp_valid <= 1, unit inputs <= IDLE_ABC, state <= RESP.
  - For LAT=1: operands on the unit from T+1, d sampled in cycle T+2, rsp_valid=1 from T+3.
- RESP:
  - rsp_valid, rsp_id and rsp_d are held stable until rsp_ready=1.
  - On acceptance: rsp_valid <= 0, state <= IDLE.
  - Next grant is possible no earlier than the cycle after acceptance.
  - Throughput: at most one operation per LAT+3 cycles.
- Fairness: a continuously asserted requester is granted within NREQ operations. req_valid dropped before a grant is not remembered.
- NREQ=1: rr_ptr stays 0 and rsp_id is always 0.
- Wrap-around: with rr_ptr=NREQ-1, the search continues from index 0.
- Simultaneous rst with a handshake or rsp_ready: rst wins.
- req_* changes after the handshake have no effect on the operation in flight.

Decomposition:
- Package test2_arb_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Function idw(n) returning max(1, clog2(n)).
  - Constant for the cnt width (4 bits).
- Sub-module rr_pick:
  - Combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, found flag, winner index.
  - Instantiated once; testable standalone.

Test Plan:
- Single request (NREQ=4, LAT=1): req_valid=4'b0100 with a=1, b=0, c=1 at cycle T. Expect:
  - req_ready=4'b0100 in cycle T.
  - unit_a/b/c=1/0/1 from T+1.
  - rsp_valid=1 from T+3 with rsp_id=2 and rsp_d equal to the unit_d value sampled at T+2.
  - rr_ptr=3 afterwards.
- Round-robin, all four requesters valid continuously, rsp_ready=1: grant order 0, 1, 2, 3, 0; successive handshakes exactly 4 cycles apart (LAT=1).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Expect rsp_valid/rsp_id/rsp_d stable, req_ready=0, busy=1; IDLE entered the cycle after rsp_ready=1.
- Latency parameter LAT=3: expect unit inputs held for 4 cycles, rsp_valid at T+5, and d sampled exactly at the edge ending cycle T+4.
- Reset mid-operation: assert rst during WAIT. Expect next cycle:
  - state IDLE, unit_a/b/c=1/1/1, rsp_valid=0, rr_ptr=0.
  - No response for the aborted request.
  - Next grant goes to the lowest valid index.
- Wrap-around with NREQ=4, rr_ptr=3, req_valid=4'b0011: expect grant to requester 0, then rr_ptr=1.
